mem_arbiter: RTL and testbench

Shares a single-port, fixed-latency unified memory between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the pipelined MIPS core. It serialises accesses, gives priority to the older instruction (MEM stage), counts out the memory latency, and produces per-stage ready and stall signals. The hazard unit and pipeline registers use those signals to freeze PC, IF/ID and the MEM stage.

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IF/MEM pipeline stages, the arbiter and the unified memory.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Instruction-fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              if_stall;

    // Data-memory port
    logic              dm_read;
    logic              dm_write;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;
    logic              dm_stall;

    // Memory side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              arb_busy;

    // Arbiter view
    modport slave (
        input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, if_stall, dm_rdata, dm_ready, dm_stall,
        output mem_en, mem_we, mem_addr, mem_wdata, arb_busy
    );

    // Pipeline/memory environment view
    modport master (
        output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, if_stall, dm_rdata, dm_ready, dm_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata, arb_busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing a single-port fixed-latency memory between IF and MEM stages.
// MEM stage has priority; one access in flight at a time; ready pulses and
// stalls are combinational so the pipeline freezes for exactly the right cycles.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_IF = 2'd1;
    localparam logic [1:0] BUSY_DM = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              own_we;
    logic              own_we_nxt;

    logic              dm_req_c;
    logic [DATA_W-1:0] if_rdata_c;
    logic              if_ready_c;
    logic [DATA_W-1:0] dm_rdata_c;
    logic              dm_ready_c;
    logic              mem_en_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic              busy_c;

    // A simultaneous read+write request is a store.
    assign dm_req_c = bus.dm_read | bus.dm_write;

    // State, latency counter and owner write flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            own_we <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            own_we <= own_we_nxt;
        end
    end

    // Grant, latency countdown and completion decode; all outputs forced low in reset.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        own_we_nxt  = own_we;
        if_rdata_c  = '0;
        if_ready_c  = 1'b0;
        dm_rdata_c  = '0;
        dm_ready_c  = 1'b0;
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        busy_c      = 1'b0;

        case (state)
            IDLE: begin
                if (dm_req_c) begin
                    mem_en_c    = 1'b1;
                    mem_we_c    = bus.dm_write;
                    mem_addr_c  = bus.dm_addr;
                    mem_wdata_c = bus.dm_wdata;
                    cnt_nxt     = CNT_INIT;
                    own_we_nxt  = bus.dm_write;
                    state_nxt   = BUSY_DM;
                end else if (bus.if_req) begin
                    mem_en_c    = 1'b1;
                    mem_addr_c  = bus.if_addr;
                    cnt_nxt     = CNT_INIT;
                    own_we_nxt  = 1'b0;
                    state_nxt   = BUSY_IF;
                end
            end
            BUSY_IF: begin
                busy_c = 1'b1;
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else begin
                    // A flushed fetch still drains; only the ready is suppressed.
                    if (bus.if_req) begin
                        if_ready_c = 1'b1;
                        if_rdata_c = bus.mem_rdata;
                    end
                    state_nxt = IDLE;
                end
            end
            BUSY_DM: begin
                busy_c = 1'b1;
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else begin
                    if (dm_req_c) begin
                        dm_ready_c = 1'b1;
                        dm_rdata_c = own_we ? '0 : bus.mem_rdata;
                    end
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (rst) begin
            if_rdata_c  = '0;
            if_ready_c  = 1'b0;
            dm_rdata_c  = '0;
            dm_ready_c  = 1'b0;
            mem_en_c    = 1'b0;
            mem_we_c    = 1'b0;
            mem_addr_c  = '0;
            mem_wdata_c = '0;
            busy_c      = 1'b0;
        end
    end

    assign bus.if_rdata  = if_rdata_c;
    assign bus.if_ready  = if_ready_c;
    assign bus.if_stall  = bus.if_req & ~if_ready_c;
    assign bus.dm_rdata  = dm_rdata_c;
    assign bus.dm_ready  = dm_ready_c;
    assign bus.dm_stall  = dm_req_c & ~dm_ready_c;
    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.arb_busy  = busy_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=2 and MEM_LAT=1) share one
// stimulus stream; a transaction-level model checks both every cycle, and
// directed sequences pin key cycle-exact expectations with literals.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model state per instance: access in flight, issue cycle, owner, store flag
    bit m_busy   [2] = '{0, 0};
    int m_issue  [2] = '{0, 0};
    bit m_own_dm [2] = '{0, 0};
    bit m_write  [2] = '{0, 0};

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ia ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ib ();

    assign ia.if_req    = if_req;
    assign ia.if_addr   = if_addr;
    assign ia.dm_read   = dm_read;
    assign ia.dm_write  = dm_write;
    assign ia.dm_addr   = dm_addr;
    assign ia.dm_wdata  = dm_wdata;
    assign ia.mem_rdata = mem_rdata;
    assign ib.if_req    = if_req;
    assign ib.if_addr   = if_addr;
    assign ib.dm_read   = dm_read;
    assign ib.dm_write  = dm_write;
    assign ib.dm_addr   = dm_addr;
    assign ib.dm_wdata  = dm_wdata;
    assign ib.mem_rdata = mem_rdata;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_b (.clk(clk), .rst(rst), .bus(ib));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level reference: an access issued at cycle t completes at t+lat.
    task automatic model_check(input int id, input int lat, input string p,
                               input logic [31:0] if_rdata_a, input logic if_ready_a,
                               input logic if_stall_a, input logic [31:0] dm_rdata_a,
                               input logic dm_ready_a, input logic dm_stall_a,
                               input logic mem_en_a, input logic mem_we_a,
                               input logic [31:0] mem_addr_a, input logic [31:0] mem_wdata_a,
                               input logic busy_a);
        logic [31:0] e_if_rdata, e_dm_rdata, e_addr, e_wdata;
        logic        e_if_ready, e_dm_ready, e_en, e_we, e_busy, dmreq;
        e_if_rdata = 0; e_dm_rdata = 0; e_addr = 0; e_wdata = 0;
        e_if_ready = 0; e_dm_ready = 0; e_en = 0; e_we = 0; e_busy = 0;
        dmreq = dm_read | dm_write;
        if (rst) begin
            m_busy[id] = 0;
        end else if (!m_busy[id]) begin
            if (dmreq) begin
                e_en = 1; e_we = dm_write; e_addr = dm_addr; e_wdata = dm_wdata;
                m_busy[id] = 1; m_issue[id] = cyc; m_own_dm[id] = 1; m_write[id] = dm_write;
            end else if (if_req) begin
                e_en = 1; e_addr = if_addr;
                m_busy[id] = 1; m_issue[id] = cyc; m_own_dm[id] = 0; m_write[id] = 0;
            end
        end else begin
            e_busy = 1;
            if (cyc - m_issue[id] == lat) begin
                if (m_own_dm[id]) begin
                    if (dmreq) begin
                        e_dm_ready = 1;
                        e_dm_rdata = m_write[id] ? 32'h0 : mem_rdata;
                    end
                end else if (if_req) begin
                    e_if_ready = 1;
                    e_if_rdata = mem_rdata;
                end
                m_busy[id] = 0;
            end
        end
        check({p, "if_rdata"},  if_rdata_a,        e_if_rdata);
        check({p, "if_ready"},  32'(if_ready_a),   32'(e_if_ready));
        check({p, "if_stall"},  32'(if_stall_a),   32'(if_req & ~e_if_ready));
        check({p, "dm_rdata"},  dm_rdata_a,        e_dm_rdata);
        check({p, "dm_ready"},  32'(dm_ready_a),   32'(e_dm_ready));
        check({p, "dm_stall"},  32'(dm_stall_a),   32'(dmreq & ~e_dm_ready));
        check({p, "mem_en"},    32'(mem_en_a),     32'(e_en));
        check({p, "mem_we"},    32'(mem_we_a),     32'(e_we));
        check({p, "mem_addr"},  mem_addr_a,        e_addr);
        check({p, "mem_wdata"}, mem_wdata_a,       e_wdata);
        check({p, "arb_busy"},  32'(busy_a),       32'(e_busy));
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        model_check(0, 2, "A.", ia.if_rdata, ia.if_ready, ia.if_stall, ia.dm_rdata,
                    ia.dm_ready, ia.dm_stall, ia.mem_en, ia.mem_we, ia.mem_addr,
                    ia.mem_wdata, ia.arb_busy);
        model_check(1, 1, "B.", ib.if_rdata, ib.if_ready, ib.if_stall, ib.dm_rdata,
                    ib.dm_ready, ib.dm_stall, ib.mem_en, ib.mem_we, ib.mem_addr,
                    ib.mem_wdata, ib.arb_busy);
        cyc++;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 0; if_addr = 0; dm_read = 0; dm_write = 0; dm_addr = 0; dm_wdata = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            next_cycle();
            clear_inputs();
            mem_rdata = $urandom;
        end
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        mem_rdata = 0;

        // Reset: outputs low, stall still follows request
        @(negedge clk);
        check("rst_mem_en", 32'(ia.mem_en), 32'h0);
        check("rst_busy", 32'(ia.arb_busy), 32'h0);
        next_cycle();
        if_req = 1; if_addr = 32'h100;
        @(negedge clk);
        check("rst_req_mem_en", 32'(ia.mem_en), 32'h0);
        check("rst_req_if_stall", 32'(ia.if_stall), 32'h1);
        next_cycle();
        rst = 0;
        clear_inputs();
        idle(3);

        // Single fetch, MEM_LAT=2
        next_cycle();
        if_req = 1; if_addr = 32'h100;
        @(negedge clk);
        check("fetch_c0_mem_en", 32'(ia.mem_en), 32'h1);
        check("fetch_c0_mem_we", 32'(ia.mem_we), 32'h0);
        check("fetch_c0_mem_addr", ia.mem_addr, 32'h100);
        check("fetch_c0_stall", 32'(ia.if_stall), 32'h1);
        next_cycle();
        @(negedge clk);
        check("fetch_c1_stall", 32'(ia.if_stall), 32'h1);
        check("fetch_c1_mem_en", 32'(ia.mem_en), 32'h0);
        next_cycle();
        mem_rdata = 32'h2402000A;
        @(negedge clk);
        check("fetch_c2_ready", 32'(ia.if_ready), 32'h1);
        check("fetch_c2_rdata", ia.if_rdata, 32'h2402000A);
        check("fetch_c2_stall", 32'(ia.if_stall), 32'h0);
        idle(3);

        // Simultaneous IF and DM: DM first
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            if_req = (c < 6); if_addr = 32'h200;
            dm_read = (c < 3); dm_addr = 32'h400;
            mem_rdata = 32'hA000_0000 + 32'(c);
            @(negedge clk);
            check("sim_mem_en", 32'(ia.mem_en), 32'((c == 0) || (c == 3)));
            if (c == 0) check("sim_c0_addr", ia.mem_addr, 32'h400);
            if (c == 3) check("sim_c3_addr", ia.mem_addr, 32'h200);
            check("sim_dm_ready", 32'(ia.dm_ready), 32'(c == 2));
            check("sim_if_ready", 32'(ia.if_ready), 32'(c == 5));
        end
        idle(3);

        // Store
        next_cycle();
        dm_write = 1; dm_addr = 32'h404; dm_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("st_c0_mem_en", 32'(ia.mem_en), 32'h1);
        check("st_c0_mem_we", 32'(ia.mem_we), 32'h1);
        check("st_c0_addr", ia.mem_addr, 32'h404);
        check("st_c0_wdata", ia.mem_wdata, 32'hDEADBEEF);
        next_cycle();
        @(negedge clk);
        check("st_c1_mem_en", 32'(ia.mem_en), 32'h0);
        check("st_c1_wdata", ia.mem_wdata, 32'h0);
        next_cycle();
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        check("st_c2_ready", 32'(ia.dm_ready), 32'h1);
        check("st_c2_rdata", ia.dm_rdata, 32'h0);
        idle(3);

        // Flush: fetch dropped after issue, load arrives meanwhile
        next_cycle();
        if_req = 1; if_addr = 32'h300;
        @(negedge clk);
        check("fl_c0_mem_en", 32'(ia.mem_en), 32'h1);
        next_cycle();
        if_req = 0; dm_read = 1; dm_addr = 32'h408;
        @(negedge clk);
        check("fl_c1_busy", 32'(ia.arb_busy), 32'h1);
        check("fl_c1_dm_stall", 32'(ia.dm_stall), 32'h1);
        next_cycle();
        @(negedge clk);
        check("fl_c2_if_ready", 32'(ia.if_ready), 32'h0);
        check("fl_c2_busy", 32'(ia.arb_busy), 32'h1);
        check("fl_c2_mem_en", 32'(ia.mem_en), 32'h0);
        next_cycle();
        @(negedge clk);
        check("fl_c3_mem_en", 32'(ia.mem_en), 32'h1);
        check("fl_c3_addr", ia.mem_addr, 32'h408);
        check("fl_c3_busy", 32'(ia.arb_busy), 32'h0);
        idle(4);

        // Reset mid-access with one latency cycle left
        next_cycle();
        dm_read = 1; dm_addr = 32'h40C;
        next_cycle();
        rst = 1; dm_read = 0;
        @(negedge clk);
        check("rm_c1_busy", 32'(ia.arb_busy), 32'h0);
        next_cycle();
        rst = 0; mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        check("rm_c2_dm_ready", 32'(ia.dm_ready), 32'h0);
        check("rm_c2_dm_rdata", ia.dm_rdata, 32'h0);
        check("rm_c2_busy", 32'(ia.arb_busy), 32'h0);
        check("rm_c2_mem_en", 32'(ia.mem_en), 32'h0);
        idle(3);

        // MEM_LAT=1 back-to-back fetches
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            if_req = 1; if_addr = 32'h500;
            mem_rdata = 32'hB000_0000 + 32'(c);
            @(negedge clk);
            check("l1_mem_en", 32'(ib.mem_en), 32'((c % 2) == 0));
            check("l1_if_ready", 32'(ib.if_ready), 32'((c % 2) == 1));
        end
        idle(3);

        // Randomized traffic with flushes and occasional resets
        repeat (3000) begin
            next_cycle();
            rst = ($urandom_range(0, 199) == 0);
            if (if_req) begin
                if ($urandom_range(0, 19) == 0) if_req = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                if_req = 1;
                if_addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            end
            if (dm_read | dm_write) begin
                if ($urandom_range(0, 14) == 0) begin
                    dm_read = 0; dm_write = 0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0, 1:    begin dm_read = 1; dm_write = 0; end
                    2:       begin dm_read = 0; dm_write = 1; end
                    default: begin dm_read = 1; dm_write = 1; end
                endcase
                dm_addr  = $urandom;
                dm_wdata = $urandom;
            end
            mem_rdata = $urandom;
        end
        next_cycle();
        rst = 0;
        clear_inputs();
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
